// File: rtl/writeback_stage.sv
// writeback_stage
//   Final pipeline stage. Accepts results from the load path (mem_*) and the
//   ALU path (alu_*) over valid/ready handshakes and applies the register
//   width rule as each result is enqueued: indices 0-27 keep 16 bits and
//   28-31 keep 24 bits. Results sit in an in-order queue and drain one per
//   cycle into the registered register-file write port (rf_write_*). Writes
//   that are still pending are forwarded to the operand-read stage.
//
// Ports
//   clk, rst_n             clock, synchronous active-low reset
//   mem_valid/ready/index/data   load result handshake (higher priority)
//   alu_valid/ready/index/data   ALU result handshake
//   flush                  discard all queued entries at the next edge
//   rf_write_enable/index/data   registered register-file write port
//   fwd_index_1/2          operand indices being read
//   fwd_hit_1/2, fwd_data_1/2    youngest pending write for each index
//   pending_count          queued entries, not counting the output register
//
// Build option
//   WB_ZERO_R0_EN  when defined, index 0 is hardwired zero: results to r0
//                  complete their handshake but are never enqueued, and
//                  forwarding never hits on index 0.

module writeback_stage #(
  parameter int DEPTH  = 4,
  parameter int IDX_W  = 5,
  parameter int DATA_W = 24
) (
  input  logic                     clk,
  input  logic                     rst_n,

  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [IDX_W-1:0]         mem_index,
  input  logic [DATA_W-1:0]        mem_data,

  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [IDX_W-1:0]         alu_index,
  input  logic [DATA_W-1:0]        alu_data,

  input  logic                     flush,

  output logic                     rf_write_enable,
  output logic [IDX_W-1:0]         rf_write_index,
  output logic [DATA_W-1:0]        rf_write_data,

  input  logic [IDX_W-1:0]         fwd_index_1,
  input  logic [IDX_W-1:0]         fwd_index_2,
  output logic                     fwd_hit_1,
  output logic [DATA_W-1:0]        fwd_data_1,
  output logic                     fwd_hit_2,
  output logic [DATA_W-1:0]        fwd_data_2,

  output logic [$clog2(DEPTH):0]   pending_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [IDX_W-1:0]  q_idx  [DEPTH];
  logic [DATA_W-1:0] q_data [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;

  logic              full;
  logic              empty;
  logic              mem_xfer;
  logic              alu_xfer;
  logic [IDX_W-1:0]  in_idx;
  logic [DATA_W-1:0] in_raw;
  logic [DATA_W-1:0] in_data;
  logic              zero_drop;
  logic              push;
  logic              pop;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // mem is older in program order, so it always wins the single slot.
  assign mem_ready = !full && !flush;
  assign alu_ready = !full && !mem_valid && !flush;

  assign mem_xfer = mem_valid && mem_ready;
  assign alu_xfer = alu_valid && alu_ready;

  assign in_idx = mem_xfer ? mem_index : alu_index;
  assign in_raw = mem_xfer ? mem_data  : alu_data;

  // Narrow registers keep only their low 16 bits, zero-extended.
  assign in_data = (in_idx < IDX_W'(28)) ? {{(DATA_W-16){1'b0}}, in_raw[15:0]} : in_raw;

`ifdef WB_ZERO_R0_EN
  assign zero_drop = (in_idx == '0);
`else
  assign zero_drop = 1'b0;
`endif

  assign push = (mem_xfer || alu_xfer) && !zero_drop;
  assign pop  = !empty && !flush;

  // Storage needs no reset: only slots inside the head..tail window are read.
  always_ff @(posedge clk) begin
    if (push) begin
      q_idx[tail]  <= in_idx;
      q_data[tail] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head            <= '0;
      tail            <= '0;
      count           <= '0;
      rf_write_enable <= 1'b0;
      rf_write_index  <= '0;
      rf_write_data   <= '0;
    end else if (flush) begin
      // The write already in the output register completes this edge;
      // nothing new is presented behind it.
      head            <= '0;
      tail            <= '0;
      count           <= '0;
      rf_write_enable <= 1'b0;
    end else begin
      if (pop) begin
        rf_write_enable <= 1'b1;
        rf_write_index  <= q_idx[head];
        rf_write_data   <= q_data[head];
        head            <= head + PTR_W'(1);
      end else begin
        rf_write_enable <= 1'b0;
      end
      if (push) begin
        tail <= tail + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (!push && pop) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  assign pending_count = count;

  // Forwarding: start from the output register (oldest pending write), then
  // walk the queue from head to tail so the youngest match ends up winning.
  always_comb begin
    logic [PTR_W-1:0] slot;
    slot       = '0;
    fwd_hit_1  = rf_write_enable && (rf_write_index == fwd_index_1);
    fwd_data_1 = fwd_hit_1 ? rf_write_data : '0;
    fwd_hit_2  = rf_write_enable && (rf_write_index == fwd_index_2);
    fwd_data_2 = fwd_hit_2 ? rf_write_data : '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot = head + PTR_W'(i);
      if (CNT_W'(i) < count) begin
        if (q_idx[slot] == fwd_index_1) begin
          fwd_hit_1  = 1'b1;
          fwd_data_1 = q_data[slot];
        end
        if (q_idx[slot] == fwd_index_2) begin
          fwd_hit_2  = 1'b1;
          fwd_data_2 = q_data[slot];
        end
      end
    end
`ifdef WB_ZERO_R0_EN
    if (fwd_index_1 == '0) begin
      fwd_hit_1  = 1'b0;
      fwd_data_1 = '0;
    end
    if (fwd_index_2 == '0) begin
      fwd_hit_2  = 1'b0;
      fwd_data_2 = '0;
    end
`endif
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Testbench for writeback_stage: directed scenarios followed by randomized
// traffic, all compared against a queue-based reference model.

module tb_writeback_stage;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_index;
  logic [23:0] mem_data;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_index;
  logic [23:0] alu_data;
  logic        flush;
  logic        rf_write_enable;
  logic [4:0]  rf_write_index;
  logic [23:0] rf_write_data;
  logic [4:0]  fwd_index_1;
  logic [4:0]  fwd_index_2;
  logic        fwd_hit_1;
  logic [23:0] fwd_data_1;
  logic        fwd_hit_2;
  logic [23:0] fwd_data_2;
  logic [2:0]  pending_count;

  writeback_stage #(.DEPTH(DEPTH), .IDX_W(5), .DATA_W(24)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_index(mem_index), .mem_data(mem_data),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_index(alu_index), .alu_data(alu_data),
    .flush(flush),
    .rf_write_enable(rf_write_enable), .rf_write_index(rf_write_index), .rf_write_data(rf_write_data),
    .fwd_index_1(fwd_index_1), .fwd_index_2(fwd_index_2),
    .fwd_hit_1(fwd_hit_1), .fwd_data_1(fwd_data_1),
    .fwd_hit_2(fwd_hit_2), .fwd_data_2(fwd_data_2),
    .pending_count(pending_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference model: pending writes in program order plus the output register.
  typedef struct packed {
    logic [4:0]  idx;
    logic [23:0] data;
  } ent_t;

  ent_t        q[$];
  logic        m_en   = 1'b0;
  logic [4:0]  m_idx  = '0;
  logic [23:0] m_data = '0;

  function automatic logic [23:0] width_rule(input logic [4:0] idx, input logic [23:0] d);
    return (idx < 5'd28) ? {8'h00, d[15:0]} : d;
  endfunction

  function automatic logic [24:0] model_fwd(input logic [4:0] k);
`ifdef WB_ZERO_R0_EN
    if (k == 5'd0) return 25'd0;
`endif
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].idx == k) return {1'b1, q[i].data};
    if (m_en && m_idx == k) return {1'b1, m_data};
    return 25'd0;
  endfunction

  function automatic void model_push(input logic [4:0] idx, input logic [23:0] d);
    ent_t e;
`ifdef WB_ZERO_R0_EN
    if (idx == 5'd0) return;
`endif
    e.idx  = idx;
    e.data = width_rule(idx, d);
    q.push_back(e);
  endfunction

  // One clock cycle: drive inputs after the falling edge, compare every
  // output with the model, then advance the model across the next rising edge.
  task automatic step(input logic rn,
                      input logic mv, input logic [4:0] mi, input logic [23:0] md,
                      input logic av, input logic [4:0] ai, input logic [23:0] ad,
                      input logic fl, input logic [4:0] f1, input logic [4:0] f2);
    logic        full;
    logic        e_mrdy;
    logic        e_ardy;
    logic [24:0] e_f1;
    logic [24:0] e_f2;
    ent_t        e;
    @(negedge clk);
    rst_n = rn; mem_valid = mv; mem_index = mi; mem_data = md;
    alu_valid = av; alu_index = ai; alu_data = ad; flush = fl;
    fwd_index_1 = f1; fwd_index_2 = f2;
    #1;
    full   = (q.size() == DEPTH);
    e_mrdy = !full && !fl;
    e_ardy = !full && !mv && !fl;
    e_f1   = model_fwd(f1);
    e_f2   = model_fwd(f2);
    check("rf_write_enable", 32'(rf_write_enable), 32'(m_en));
    check("rf_write_index",  32'(rf_write_index),  32'(m_idx));
    check("rf_write_data",   32'(rf_write_data),   32'(m_data));
    check("pending_count",   32'(pending_count),   32'(q.size()));
    check("mem_ready",       32'(mem_ready),       32'(e_mrdy));
    check("alu_ready",       32'(alu_ready),       32'(e_ardy));
    check("fwd_1",           {7'd0, fwd_hit_1, fwd_data_1}, {7'd0, e_f1});
    check("fwd_2",           {7'd0, fwd_hit_2, fwd_data_2}, {7'd0, e_f2});
    if (!rn) begin
      q.delete(); m_en = 1'b0; m_idx = '0; m_data = '0;
    end else if (fl) begin
      q.delete(); m_en = 1'b0;
    end else begin
      if (q.size() > 0) begin
        e = q.pop_front(); m_en = 1'b1; m_idx = e.idx; m_data = e.data;
      end else begin
        m_en = 1'b0;
      end
      if (mv && e_mrdy)      model_push(mi, md);
      else if (av && e_ardy) model_push(ai, ad);
    end
  endtask

  task automatic idle(input logic [4:0] f1);
    step(1'b1, 1'b0, 5'd0, 24'd0, 1'b0, 5'd0, 24'd0, 1'b0, f1, 5'd0);
  endtask

  function automatic logic [4:0] pick_idx();
    case ($urandom_range(0, 5))
      0:       return 5'd0;
      1:       return 5'd5;
      2:       return 5'd7;
      3:       return 5'd28;
      4:       return 5'd31;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  initial begin
    rst_n = 1'b0; mem_valid = 1'b0; mem_index = '0; mem_data = '0;
    alu_valid = 1'b0; alu_index = '0; alu_data = '0; flush = 1'b0;
    fwd_index_1 = '0; fwd_index_2 = '0;

    step(1'b0, 1'b0, 5'd0, 24'd0, 1'b0, 5'd0, 24'd0, 1'b0, 5'd0, 5'd0);
    step(1'b0, 1'b0, 5'd0, 24'd0, 1'b0, 5'd0, 24'd0, 1'b0, 5'd0, 5'd0);
    idle(5'd0);
    check("reset_en",    32'(rf_write_enable), 32'd0);
    check("reset_count", 32'(pending_count),   32'd0);

    // Single narrow ALU result: visible two edges after acceptance.
    step(1'b1, 1'b0, 5'd0, 24'd0, 1'b1, 5'd5, 24'hABCDEF, 1'b0, 5'd0, 5'd0);
    idle(5'd0);
    idle(5'd0);
    check("r5_en",   32'(rf_write_enable), 32'd1);
    check("r5_idx",  32'(rf_write_index),  32'd5);
    check("r5_data", 32'(rf_write_data),   32'h00CDEF);

    // Wide register keeps 24 bits and forwards until retired.
    step(1'b1, 1'b0, 5'd0, 24'd0, 1'b1, 5'd30, 24'h123456, 1'b0, 5'd30, 5'd0);
    idle(5'd30);
    check("r30_fwd_q",   {7'd0, fwd_hit_1, fwd_data_1}, {7'd1, 24'h123456});
    idle(5'd30);
    check("r30_fwd_out", {7'd0, fwd_hit_1, fwd_data_1}, {7'd1, 24'h123456});
    check("r30_data",    32'(rf_write_data), 32'h123456);
    idle(5'd30);
    check("r30_retired", 32'(fwd_hit_1), 32'd0);

    // Both paths valid: mem always wins, alu is held off.
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 1'b1, 5'(10 + k), 24'(k + 1), 1'b1, 5'd20, 24'h777777, 1'b0, 5'd20, 5'(10 + k));
      check("both_alu_ready", 32'(alu_ready), 32'd0);
      check("both_mem_ready", 32'(mem_ready), 32'd1);
    end
    idle(5'd0);
    idle(5'd0);

    // Two writes to r7: forwarding returns the younger one.
    step(1'b1, 1'b0, 5'd0, 24'd0, 1'b1, 5'd7, 24'h000011, 1'b0, 5'd7, 5'd0);
    step(1'b1, 1'b0, 5'd0, 24'd0, 1'b1, 5'd7, 24'h000022, 1'b0, 5'd7, 5'd0);
    idle(5'd7);
    check("r7_fwd_young", 32'(fwd_data_1),    32'h000022);
    check("r7_first",     32'(rf_write_data), 32'h000011);
    idle(5'd7);
    check("r7_second",    32'(rf_write_data), 32'h000022);
    idle(5'd0);

    // Flush with a write in the output register and one entry queued.
    step(1'b1, 1'b0, 5'd0, 24'd0, 1'b1, 5'd9,  24'h000001, 1'b0, 5'd0, 5'd0);
    step(1'b1, 1'b0, 5'd0, 24'd0, 1'b1, 5'd10, 24'h000002, 1'b0, 5'd0, 5'd0);
    step(1'b1, 1'b0, 5'd0, 24'd0, 1'b1, 5'd11, 24'h000003, 1'b1, 5'd10, 5'd0);
    check("flush_alu_ready", 32'(alu_ready),       32'd0);
    check("flush_completes", 32'(rf_write_enable), 32'd1);
    idle(5'd10);
    check("flush_en_after",  32'(rf_write_enable), 32'd0);
    check("flush_count",     32'(pending_count),   32'd0);
    check("flush_no_fwd",    32'(fwd_hit_1),       32'd0);
    idle(5'd0);

    // Index 0 handling.
    step(1'b1, 1'b0, 5'd0, 24'd0, 1'b1, 5'd0, 24'h00FFFF, 1'b0, 5'd0, 5'd0);
    check("r0_alu_ready", 32'(alu_ready), 32'd1);
    idle(5'd0);
    idle(5'd0);
`ifdef WB_ZERO_R0_EN
    check("r0_no_write", 32'(rf_write_enable), 32'd0);
    check("r0_no_fwd",   32'(fwd_hit_1),       32'd0);
`else
    check("r0_write",    32'(rf_write_enable), 32'd1);
    check("r0_data",     32'(rf_write_data),   32'h00FFFF);
`endif

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 63) != 0),
           ($urandom_range(0, 2) == 0), pick_idx(), 24'($urandom),
           ($urandom_range(0, 1) == 0), pick_idx(), 24'($urandom),
           ($urandom_range(0, 15) == 0), pick_idx(), pick_idx());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
